mem_issue_select: RTL and testbench
===================================

Name: mem_issue_select

Overview:
- Sits directly downstream of the two-bank in-order memory issue queue.
- Takes the head entry of each bank and picks the oldest by active-list (AL) age each cycle.
- Places the pick in a 2-entry output skid buffer that feeds the single memory/AGU port.
- Squashes wrong-path entries on a branch recall and reports an internal stall upstream.

Parameters:
- AL_SIZE, 64: active-list entries; must be a power of 2; AW = log2(AL_SIZE).
- PAYLOAD_W, 96: width of the opaque micro-op payload (opcode, tags, imm, rob id); passed through unmodified.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ext_stall  in  1  freezes output pop and input accept
- if_recall  in  1  branch recall pulse, one cycle
- new_front  in  AW  AL allocation pointer after recall; entries at or after it are squashed
- back  in  AW  AL oldest (retire) pointer, age origin
- i_valid  in  2  bank head valid, [0]=bank0
- i_al_addr  in  2xAW  AL address of each bank head
- i_payload  in  2xPAYLOAD_W  micro-op of each bank head
- i_ready  out  2  pop strobe back to each bank
- o_valid  out  1  memory port request valid
- o_ready  in  1  memory port accepts
- o_al_addr  out  AW  AL address of output entry
- o_payload  out  PAYLOAD_W  output micro-op
- int_stall  out  1  buffer full or ext_stall
- issued_cnt  out  32  count of entries popped at output, saturating

Behaviour:
- Age:
  - age(x) = (x - back) mod AL_SIZE, computed in AW bits. Smaller age is older.
  - Compare ages, never raw addresses; wrap-around must be correct.
- Selection (combinational):
  - Both i_valid set: pick the smaller age.
  - Equal ages: pick bank 0.
  - One i_valid set: pick that bank.
  - Neither set: no pick.
- Accept:
  - i_ready[k] = pick==k AND count<2 AND !ext_stall AND !if_recall.
  - At most one bit of i_ready is high per cycle.
  - No accept in the recall cycle.
- Buffer: 2-entry FIFO, count in 0..2.
  - Push on accept.
  - Pop when o_valid AND o_ready AND !ext_stall.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO order is preserved.
- Latency: an entry accepted at edge N has o_valid=1 from cycle N+1, when the buffer was empty or its predecessor popped.
- Output:
  - o_valid = count>0.
  - o_al_addr and o_payload show the head entry and are stable while o_valid AND !pop.
  - With ext_stall=1, o_valid may stay high but no pop occurs and issued_cnt does not increment.
- Recall, evaluated in the if_recall cycle:
  - Every buffered entry with age(al_addr) >= age(new_front) is invalidated at the edge.
  - The survivors, always the older prefix, stay in order and count is recomputed.
  - A pop in the recall cycle takes priority; a popped entry is not counted as squashed.
- int_stall = (count==2) OR ext_stall, combinational.
- issued_cnt increments by 1 per pop and saturates at 2^32-1.
- Reset, at the edge:
  - count=0, o_valid=0, issued_cnt=0, i_ready=0.
  - Contents of the buffer storage are don't-care.
  - Reset overrides recall and accept in the same cycle.
  - Reset mid-operation discards all entries.
- Full: count==2 holds i_ready=0. A pop when full does not allow an accept in that same cycle (no same-cycle refill).
- Empty: o_valid=0; o_al_addr and o_payload are don't-care.

Test Plan:
- Age order across wrap: AL_SIZE=64, back=60; bank0 al=2, bank1 al=62, both valid -> i_ready=2'b10 (bank1 first); next cycle o_al_addr=62; following accept takes bank0, o_al_addr=2 after pop.
- Tie and back-pressure: both banks stream with o_ready=0 -> exactly 2 accepts, then int_stall=1, i_ready=0; set o_ready=1 -> one pop per cycle, issued_cnt counts 1,2,... and accepts resume one cycle after count drops below 2.
- Recall squash: back=0, buffer holds al=5 (head) and al=9, new_front=7, if_recall=1, o_ready=0 -> next cycle count=1, o_al_addr=5; i_ready=0 during the recall cycle.
- Recall with pop: same setup with o_ready=1 -> al=5 issues, al=9 squashed, count=0, issued_cnt+1.
- ext_stall: count=1, o_ready=1, ext_stall=1 for 3 cycles -> no pop, no accept, int_stall=1, issued_cnt unchanged; release -> pop on the next edge.
- Reset mid-flight: count=2, assert reset for one cycle -> o_valid=0, issued_cnt=0, and the next valid bank head is accepted the cycle after reset drops.

Source files
------------

// File: rtl/mem_issue_select_if.sv
// Handshake bundle between the two-bank memory issue queue heads, the
// issue selector and the single memory/AGU port.
interface mem_issue_select_if #(
    parameter int AW        = 6,
    parameter int PAYLOAD_W = 96
);
    logic [1:0]                      i_valid;
    logic [1:0][AW-1:0]              i_al_addr;
    logic [1:0][PAYLOAD_W-1:0]       i_payload;
    logic [1:0]                      i_ready;
    logic                            o_valid;
    logic                            o_ready;
    logic [AW-1:0]                   o_al_addr;
    logic [PAYLOAD_W-1:0]            o_payload;

    modport master (
        output i_valid, i_al_addr, i_payload, o_ready,
        input  i_ready, o_valid, o_al_addr, o_payload
    );

    modport slave (
        input  i_valid, i_al_addr, i_payload, o_ready,
        output i_ready, o_valid, o_al_addr, o_payload
    );
endinterface

// File: rtl/mem_issue_select.sv
// Oldest-first pick between two bank heads into a 2-entry skid buffer feeding
// the memory port, with branch-recall squash of wrong-path buffered entries.
module mem_issue_select #(
    parameter int  AL_SIZE   = 64,
    parameter int  PAYLOAD_W = 96,
    localparam int AW        = $clog2(AL_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ext_stall,
    input  logic                 if_recall,
    input  logic [AW-1:0]        new_front,
    input  logic [AW-1:0]        back,
    mem_issue_select_if.slave    bus,
    output logic                 int_stall,
    output logic [31:0]          issued_cnt
);

    function automatic logic [AW-1:0] age_f(input logic [AW-1:0] addr,
                                            input logic [AW-1:0] origin);
        age_f = addr - origin;
    endfunction

    logic [1:0]           count_r;
    logic [1:0]           count_n_s;
    logic [1:0]           base_s;
    logic                 o_valid_r;
    logic [AW-1:0]        addr_r   [2];
    logic [AW-1:0]        addr_n_s [2];
    logic [PAYLOAD_W-1:0] pay_r    [2];
    logic [PAYLOAD_W-1:0] pay_n_s  [2];
    logic [AW-1:0]        age0_s, age1_s, age_nf_s;
    logic [AW-1:0]        sel_addr_s;
    logic [PAYLOAD_W-1:0] sel_pay_s;
    logic                 pick0_s, pick1_s, can_acc_s, acc_s, pop_s;
    logic                 keep0_s, keep1_s;

    // Age-ordered pick, accept/pop handshake and recall survivor test
    always_comb begin
        age0_s    = age_f(bus.i_al_addr[0], back);
        age1_s    = age_f(bus.i_al_addr[1], back);
        age_nf_s  = age_f(new_front, back);
        pick1_s   = bus.i_valid[1] && (!bus.i_valid[0] || (age1_s < age0_s));
        pick0_s   = bus.i_valid[0] && !pick1_s;
        can_acc_s = (count_r < 2'd2) && !ext_stall && !if_recall && !reset;
        bus.i_ready = {pick1_s && can_acc_s, pick0_s && can_acc_s};
        acc_s     = pick0_s || pick1_s ? can_acc_s : 1'b0;
        if (pick1_s) begin
            sel_addr_s = bus.i_al_addr[1];
            sel_pay_s  = bus.i_payload[1];
        end else begin
            sel_addr_s = bus.i_al_addr[0];
            sel_pay_s  = bus.i_payload[0];
        end
        pop_s     = (count_r != 2'd0) && bus.o_ready && !ext_stall;
        int_stall = (count_r == 2'd2) || ext_stall;
        // Survivors form the older prefix, so slot 1 only lives if slot 0 does
        keep0_s   = age_f(addr_r[0], back) < age_nf_s;
        keep1_s   = keep0_s && (age_f(addr_r[1], back) < age_nf_s);
    end

    // Next buffer contents and occupancy
    always_comb begin
        addr_n_s  = addr_r;
        pay_n_s   = pay_r;
        count_n_s = count_r;
        base_s    = pop_s ? (count_r - 2'd1) : count_r;
        if (pop_s) begin
            addr_n_s[0] = addr_r[1];
            pay_n_s[0]  = pay_r[1];
        end else begin
            addr_n_s[0] = addr_r[0];
            pay_n_s[0]  = pay_r[0];
        end
        if (if_recall) begin
            if (pop_s) begin
                count_n_s = ((count_r == 2'd2) && (age_f(addr_r[1], back) < age_nf_s)) ? 2'd1 : 2'd0;
            end else if ((count_r == 2'd0) || !keep0_s) begin
                count_n_s = 2'd0;
            end else if ((count_r == 2'd2) && keep1_s) begin
                count_n_s = 2'd2;
            end else begin
                count_n_s = 2'd1;
            end
        end else begin
            count_n_s = base_s + {1'b0, acc_s};
            if (acc_s) begin
                addr_n_s[base_s[0]] = sel_addr_s;
                pay_n_s[base_s[0]]  = sel_pay_s;
            end else begin
                count_n_s = base_s;
            end
        end
    end

    // Occupancy, output valid and saturating issue counter
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r    <= 2'd0;
            o_valid_r  <= 1'b0;
            issued_cnt <= 32'd0;
        end else begin
            count_r   <= count_n_s;
            o_valid_r <= (count_n_s != 2'd0);
            if (pop_s && (issued_cnt != 32'hFFFF_FFFF)) begin
                issued_cnt <= issued_cnt + 32'd1;
            end
        end
    end

    // Buffer storage; contents are meaningless while the slot is empty
    always_ff @(posedge clk) begin
        addr_r <= addr_n_s;
        pay_r  <= pay_n_s;
    end

    assign bus.o_valid   = o_valid_r;
    assign bus.o_al_addr = addr_r[0];
    assign bus.o_payload = pay_r[0];

endmodule

// File: tb/tb_mem_issue_select.sv
// Directed bench for mem_issue_select: hand-computed per-cycle handshake
// expectations plus a scoreboard queue drained by an output monitor.
module tb_mem_issue_select;
    localparam int AW = 6;
    localparam int PW = 96;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ext_stall = 1'b0;
    logic          if_recall = 1'b0;
    logic [AW-1:0] new_front = '0;
    logic [AW-1:0] back = '0;
    logic          int_stall;
    logic [31:0]   issued_cnt;

    mem_issue_select_if #(.AW(AW), .PAYLOAD_W(PW)) bus ();

    mem_issue_select #(.AL_SIZE(64), .PAYLOAD_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ext_stall  (ext_stall),
        .if_recall  (if_recall),
        .new_front  (new_front),
        .back       (back),
        .bus        (bus.slave),
        .int_stall  (int_stall),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int exp_iss = 0;
    int tag = 0;
    logic [AW+PW-1:0] sb[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pay(input int bank, input int t, input logic [AW-1:0] a);
        pay = {8'(t), 8'(bank), 74'd0, a};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        tag++;
        bus.i_valid      = v;
        bus.i_al_addr[0] = a0;
        bus.i_al_addr[1] = a1;
        bus.i_payload[0] = pay(0, tag, a0);
        bus.i_payload[1] = pay(1, tag, a1);
    endtask

    // One clock: check handshake at the negedge, record expected accepts, advance
    task automatic cyc(input logic [1:0] exp_rdy, input logic exp_ov, input logic exp_st, input string nm);
        @(negedge clk);
        chk({nm, "_i_ready"}, 128'(bus.i_ready), 128'(exp_rdy));
        chk({nm, "_o_valid"}, 128'(bus.o_valid), 128'(exp_ov));
        chk({nm, "_int_stall"}, 128'(int_stall), 128'(exp_st));
        if (exp_rdy[0]) sb.push_back({bus.i_al_addr[0], bus.i_payload[0]});
        if (exp_rdy[1]) sb.push_back({bus.i_al_addr[1], bus.i_payload[1]});
        @(posedge clk);
        #1;
    endtask

    // Drop scoreboard entries that a recall against nf squashes
    task automatic squash(input logic [AW-1:0] nf);
        logic [AW-1:0] a;
        logic [AW-1:0] an;
        logic [AW+PW-1:0] keep[$];
        an = nf - back;
        foreach (sb[i]) begin
            a = sb[i][AW+PW-1:PW];
            if (AW'(a - back) < an) keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    // Output monitor: issue count and popped entries against the scoreboard
    always @(negedge clk) begin
        logic [AW+PW-1:0] e;
        chk("issued_cnt", 128'(issued_cnt), 128'(exp_iss));
        if (reset) begin
            exp_iss = 0;
            sb.delete();
        end else if (bus.o_valid && bus.o_ready && !ext_stall) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got al %0h expected no entry", bus.o_al_addr);
            end else begin
                e = sb.pop_front();
                chk("pop_al_addr", 128'(bus.o_al_addr), 128'(e[AW+PW-1:PW]));
                chk("pop_payload", 128'(bus.o_payload), 128'(e[PW-1:0]));
            end
            exp_iss++;
        end
    end

    initial begin
        bus.o_ready = 1'b0;
        drive(2'b00, '0, '0);
        cyc(2'b00, 1'b0, 1'b0, "rst0");
        cyc(2'b00, 1'b0, 1'b0, "rst1");
        reset = 1'b0;

        // Age order across wrap
        back = 6'd60;
        drive(2'b11, 6'd2, 6'd62);
        cyc(2'b10, 1'b0, 1'b0, "wrap_pick");
        chk("wrap_head", 128'(bus.o_al_addr), 128'(62));
        drive(2'b01, 6'd2, 6'd0);
        cyc(2'b01, 1'b1, 1'b0, "wrap_second");
        drive(2'b00, 6'd0, 6'd0);
        bus.o_ready = 1'b1;
        cyc(2'b00, 1'b1, 1'b1, "wrap_pop1");
        chk("wrap_head2", 128'(bus.o_al_addr), 128'(2));
        cyc(2'b00, 1'b1, 1'b0, "wrap_pop2");
        bus.o_ready = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, "wrap_idle");

        // Tie and back-pressure
        back = 6'd0;
        drive(2'b11, 6'd10, 6'd10);
        cyc(2'b01, 1'b0, 1'b0, "bp_tie");
        drive(2'b11, 6'd11, 6'd10);
        cyc(2'b10, 1'b1, 1'b0, "bp_b1");
        drive(2'b11, 6'd11, 6'd12);
        cyc(2'b00, 1'b1, 1'b1, "bp_full0");
        cyc(2'b00, 1'b1, 1'b1, "bp_full1");
        bus.o_ready = 1'b1;
        cyc(2'b00, 1'b1, 1'b1, "bp_popfull");
        cyc(2'b01, 1'b1, 1'b0, "bp_resume");
        drive(2'b11, 6'd13, 6'd12);
        cyc(2'b10, 1'b1, 1'b0, "bp_stream");
        drive(2'b00, 6'd0, 6'd0);
        cyc(2'b00, 1'b1, 1'b0, "bp_drain");
        bus.o_ready = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, "bp_idle");

        // Recall squash without pop
        drive(2'b01, 6'd5, 6'd0);
        cyc(2'b01, 1'b0, 1'b0, "rc_a5");
        drive(2'b01, 6'd9, 6'd0);
        cyc(2'b01, 1'b1, 1'b0, "rc_a9");
        drive(2'b01, 6'd20, 6'd0);
        if_recall = 1'b1;
        new_front = 6'd7;
        cyc(2'b00, 1'b1, 1'b1, "rc_recall");
        squash(6'd7);
        if_recall = 1'b0;
        drive(2'b00, 6'd0, 6'd0);
        chk("rc_head", 128'(bus.o_al_addr), 128'(5));
        cyc(2'b00, 1'b1, 1'b0, "rc_after");
        bus.o_ready = 1'b1;
        cyc(2'b00, 1'b1, 1'b0, "rc_pop");
        bus.o_ready = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, "rc_idle");

        // Recall with simultaneous pop
        drive(2'b01, 6'd5, 6'd0);
        cyc(2'b01, 1'b0, 1'b0, "rp_a5");
        drive(2'b01, 6'd9, 6'd0);
        cyc(2'b01, 1'b1, 1'b0, "rp_a9");
        drive(2'b01, 6'd20, 6'd0);
        if_recall = 1'b1;
        bus.o_ready = 1'b1;
        cyc(2'b00, 1'b1, 1'b1, "rp_recall");
        squash(6'd7);
        if_recall = 1'b0;
        bus.o_ready = 1'b0;
        drive(2'b00, 6'd0, 6'd0);
        cyc(2'b00, 1'b0, 1'b0, "rp_empty");

        // External stall
        drive(2'b01, 6'd3, 6'd0);
        cyc(2'b01, 1'b0, 1'b0, "es_a3");
        drive(2'b01, 6'd4, 6'd0);
        bus.o_ready = 1'b1;
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b1, "es_hold");
        ext_stall = 1'b0;
        drive(2'b00, 6'd0, 6'd0);
        cyc(2'b00, 1'b1, 1'b0, "es_release");
        bus.o_ready = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, "es_idle");

        // Reset mid-flight
        drive(2'b01, 6'd1, 6'd0);
        cyc(2'b01, 1'b0, 1'b0, "mr_a1");
        drive(2'b01, 6'd2, 6'd0);
        cyc(2'b01, 1'b1, 1'b0, "mr_a2");
        drive(2'b01, 6'd7, 6'd0);
        reset = 1'b1;
        cyc(2'b00, 1'b1, 1'b1, "mr_reset");
        reset = 1'b0;
        cyc(2'b01, 1'b0, 1'b0, "mr_accept");
        drive(2'b00, 6'd0, 6'd0);
        bus.o_ready = 1'b1;
        cyc(2'b00, 1'b1, 1'b0, "mr_pop");
        bus.o_ready = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, "mr_idle");
        cyc(2'b00, 1'b0, 1'b0, "end_idle");

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
